frv_bitmanip_mc: RTL and testbench
==================================

// Module: frv_bitmanip_mc
//
// PURPOSE
// Parametrised multi-cycle bit-manipulation unit beside the single-cycle ALU in execute.
// Computes carry-less multiply (clmul/clmulh/clmulr) iteratively and crossbar permutes
// (xperm.n/b/h) in one registered cycle; these ops are too costly for the ALU's single cycle.
// Generalises to XLEN 32/64 with a configurable clmul step width; uses a valid/ready handshake.
//
// PARAMETERS
// XLEN        32  Datapath width; legal values 32 or 64.
// CLMUL_STEP   4  rs2 bits consumed per clmul cycle; power of 2 and must divide XLEN.
//
// PORTS
// g_clk      in   1     Core clock; all state updates on rising edge.
// g_reset    in   1     Synchronous, active-high reset.
// flush      in   1     Abort any in-flight op; synchronous.
// valid      in   1     Op request; op bits and rs1/rs2 held stable until ready or abort.
// op_clmul   in   1     Carry-less multiply, low half.
// op_clmulh  in   1     Carry-less multiply, high half.
// op_clmulr  in   1     Carry-less multiply, reversed (product bits [2*XLEN-2:XLEN-1]).
// op_xpermn  in   1     Crossbar permute, 4-bit elements.
// op_xpermb  in   1     Crossbar permute, 8-bit elements.
// op_xpermh  in   1     Crossbar permute, 16-bit elements.
// rs1        in   XLEN  Operand A (clmul multiplicand / xperm source table).
// rs2        in   XLEN  Operand B (clmul multiplier / xperm index vector).
// busy       out  1     High while in RUN.
// ready      out  1     One-cycle pulse: result is valid this cycle.
// result     out  XLEN  Op result; meaningful only while ready=1.
//
// BEHAVIOUR
// - Reset: state=IDLE; ready=0, busy=0, result=0, accumulator and counter=0.
// - Cycle 0 is the first cycle valid=1 in IDLE. Operands are captured at the end of cycle 0.
// - Op bits are one-hot. If all op bits are zero, ready pulses in cycle 1 with result=0.
// - FSM IDLE->RUN (clmul*), IDLE->DONE (xperm*/none), RUN->DONE on last step, DONE->IDLE.
// - DONE: ready=1 for exactly one cycle. If valid=1 in the cycle after DONE, it is a new op.
// - Latency, clmul*: ready in cycle XLEN/CLMUL_STEP + 1 (9 for 32/4). Latency, xperm*: cycle 1.
// - clmul datapath: a 2*XLEN accumulator XORs (rs1 << k) for each set bit k of rs2.
//   - Each RUN cycle consumes CLMUL_STEP bits of rs2, LSB first.
//   - A step counter of log2(XLEN/CLMUL_STEP) bits ends RUN when it reaches its max value.
// - clmul result = acc[XLEN-1:0]; clmulh = acc[2XLEN-1:XLEN]; clmulr = acc[2XLEN-2:XLEN-1].
// - xperm, element width E in {4,8,16} and N = XLEN/E elements:
//   - result element i = rs1 element rs2[i*E+:E] if that index < N, else 0.
// - flush=1 or valid=0 in any cycle in RUN/DONE: the next state is IDLE, ready is not
//   asserted, and partial state is discarded. flush takes priority over a same-cycle
//   RUN->DONE transition.
// - flush=1 together with valid=1 in IDLE: the request is ignored and the state stays IDLE.
// - g_reset takes priority over flush and valid at any point; a mid-op reset yields no ready.
// - result is held at 0 whenever ready=0, to limit toggling into the writeback mux.
// - Parameter legality is enforced by elaboration-time asserts.
//
// TESTING (XLEN=32, CLMUL_STEP=4 unless stated)
// 1 clmul rs1=0x3 rs2=0x3 -> ready in cycle 9, result=0x00000005; busy high in cycles 1-8.
// 2 rs1=rs2=0x80000000 -> clmulh=0x40000000, clmulr=0x80000000, clmul=0x00000000.
// 3 xperm.n rs1=0x76543210, rs2=0xFEDC0123 -> cycle 1 result=0x00000123.
//   xperm.b rs1=0xAABBCCDD, rs2=0x00010204 -> result=0xDDCCBB00.
// 4 clmul started, then flush=1 in cycle 4 -> no ready, IDLE in cycle 5.
//   Next xperm.h rs1=0x12345678, rs2=0x00000001 -> result=0x56781234.
// 5 g_reset=1 in cycle 3 of a clmul -> in cycle 4 ready=0, busy=0, result=0; no ready ever.
// 6 XLEN=64, CLMUL_STEP=8: clmul rs1=0xFFFFFFFFFFFFFFFF, rs2=0x3 -> ready in cycle 9,
//   result=0x0000000000000001; clmulh=0x0000000000000001.

Source files
------------

// File: rtl/frv_bitmanip_mc.sv
// ---------------------------------------------------------------------------
// frv_bitmanip_mc
// Multi-cycle bit-manipulation unit that sits beside the single-cycle ALU.
// Carry-less multiplies (clmul / clmulh / clmulr) are computed iteratively,
// consuming CLMUL_STEP multiplier bits per cycle. Crossbar permutes
// (xperm.n / xperm.b / xperm.h) take one registered cycle.
//
// Ports
//   g_clk      : core clock, rising edge
//   g_reset    : synchronous active-high reset
//   flush      : abort any in-flight operation
//   valid      : request; op bits and operands held stable until ready
//   op_clmul   : carry-less multiply, low half
//   op_clmulh  : carry-less multiply, high half
//   op_clmulr  : carry-less multiply, reversed (product bits 2*XLEN-2..XLEN-1)
//   op_xpermn  : crossbar permute, 4-bit elements
//   op_xpermb  : crossbar permute, 8-bit elements
//   op_xpermh  : crossbar permute, 16-bit elements
//   rs1, rs2   : operands (multiplicand / table, multiplier / index vector)
//   busy       : high while an iterative clmul is running
//   ready      : one-cycle pulse, result valid this cycle
//   result     : op result, forced to zero whenever ready is low
// ---------------------------------------------------------------------------
module frv_bitmanip_mc #(
  parameter int XLEN       = 32,
  parameter int CLMUL_STEP = 4
) (
  input  logic            g_clk,
  input  logic            g_reset,
  input  logic            flush,
  input  logic            valid,
  input  logic            op_clmul,
  input  logic            op_clmulh,
  input  logic            op_clmulr,
  input  logic            op_xpermn,
  input  logic            op_xpermb,
  input  logic            op_xpermh,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  localparam int STEPS = XLEN / CLMUL_STEP;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  // Reject illegal configurations while elaborating.
  if (XLEN != 32 && XLEN != 64) begin : gBadXlen
    $error("frv_bitmanip_mc: XLEN must be 32 or 64");
  end
  if (CLMUL_STEP < 1 || CLMUL_STEP > XLEN ||
      (CLMUL_STEP & (CLMUL_STEP - 1)) != 0 || (XLEN % CLMUL_STEP) != 0) begin : gBadStep
    $error("frv_bitmanip_mc: CLMUL_STEP must be a power of 2 dividing XLEN");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e              state_q, state_d;
  logic [5:0]          ops_q, ops_d;
  logic [XLEN-1:0]     rs1_q, rs1_d;
  logic [XLEN-1:0]     rs2_q, rs2_d;
  logic [2*XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic [5:0]          opsIn;
  logic                accept;
  logic                abort;
  logic [2*XLEN-1:0]   partial;
  logic [XLEN-1:0]     xpermN, xpermB, xpermH;
  logic [XLEN-1:0]     resAll;

  // Op bits packed as {xh, xb, xn, clmulr, clmulh, clmul}; bits 0..2 select the
  // iterative path. A request is only taken in IDLE and never under flush.
  assign opsIn  = {op_xpermh, op_xpermb, op_xpermn, op_clmulr, op_clmulh, op_clmul};
  assign accept = (state_q == IDLE) && valid && !flush;
  assign abort  = flush || !valid;

  // State register; reset wins over flush and valid.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Abort in RUN is checked before the last-step exit so a
  // flush on the final step still discards the op.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (|opsIn[2:0]) ? RUN : DONE;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (cnt_q == LAST_STEP) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: ready only while the requester still holds valid without flush,
  // and result is gated to zero otherwise to keep the writeback mux quiet.
  always_comb begin
    busy   = (state_q == RUN);
    ready  = (state_q == DONE) && valid && !flush;
    result = ready ? resAll : '0;
  end

  // One clmul step: XOR in the shifted multiplicand for each of the next
  // CLMUL_STEP multiplier bits. The multiplicand register is pre-shifted by
  // the bits already consumed, so bit j here weighs mcand_q << j.
  always_comb begin
    partial = '0;
    for (int j = 0; j < CLMUL_STEP; j++) begin
      if (rs2_q[j]) begin
        partial = partial ^ (mcand_q << j);
      end
    end
  end

  // Datapath next-state: capture on accept, iterate in RUN, clear on abort/DONE.
  always_comb begin
    ops_d   = ops_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          ops_d   = opsIn;
          rs1_d   = rs1;
          rs2_d   = rs2;
          mcand_d = {{XLEN{1'b0}}, rs1};
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (abort) begin
          acc_d = '0;
          cnt_d = '0;
        end else begin
          acc_d   = acc_q ^ partial;
          mcand_d = mcand_q << CLMUL_STEP;
          rs2_d   = rs2_q >> CLMUL_STEP;
          cnt_d   = cnt_q + CW'(1);
        end
      end
      DONE: begin
        acc_d = '0;
        cnt_d = '0;
      end
      default: begin
        acc_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      ops_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      mcand_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ops_q   <= ops_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Crossbar permutes from the captured operands. Each index is widened to
  // 32 bits before the range check so all element counts compare correctly;
  // out-of-range indices leave the element at zero.
  always_comb begin
    xpermN = '0;
    xpermB = '0;
    xpermH = '0;
    for (int i = 0; i < XLEN / 4; i++) begin
      if ({28'b0, rs2_q[i*4 +: 4]} < 32'(XLEN / 4)) begin
        xpermN[i*4 +: 4] = 4'(rs1_q >> {rs2_q[i*4 +: 4], 2'b00});
      end
    end
    for (int i = 0; i < XLEN / 8; i++) begin
      if ({24'b0, rs2_q[i*8 +: 8]} < 32'(XLEN / 8)) begin
        xpermB[i*8 +: 8] = 8'(rs1_q >> {rs2_q[i*8 +: 8], 3'b000});
      end
    end
    for (int i = 0; i < XLEN / 16; i++) begin
      if ({16'b0, rs2_q[i*16 +: 16]} < 32'(XLEN / 16)) begin
        xpermH[i*16 +: 16] = 16'(rs1_q >> {rs2_q[i*16 +: 16], 4'b0000});
      end
    end
  end

  // Result select from the captured one-hot op; no op bits gives zero.
  always_comb begin
    resAll = '0;
    if (ops_q[0]) begin
      resAll = acc_q[XLEN-1:0];
    end else if (ops_q[1]) begin
      resAll = acc_q[2*XLEN-1:XLEN];
    end else if (ops_q[2]) begin
      resAll = acc_q[2*XLEN-2:XLEN-1];
    end else if (ops_q[3]) begin
      resAll = xpermN;
    end else if (ops_q[4]) begin
      resAll = xpermB;
    end else if (ops_q[5]) begin
      resAll = xpermH;
    end
  end

endmodule

// File: tb/tb_frv_bitmanip_mc.sv
// ---------------------------------------------------------------------------
// tb_frv_bitmanip_mc
// Directed-vector bench for frv_bitmanip_mc. One instance at XLEN=32/STEP=4
// and one at XLEN=64/STEP=8. Inputs change 1 time unit after a rising edge
// and outputs are sampled 1 time unit later in the same cycle.
// ---------------------------------------------------------------------------
module tb_frv_bitmanip_mc;

  localparam logic [5:0] OP_NONE   = 6'b000000;
  localparam logic [5:0] OP_CLMUL  = 6'b000001;
  localparam logic [5:0] OP_CLMULH = 6'b000010;
  localparam logic [5:0] OP_CLMULR = 6'b000100;
  localparam logic [5:0] OP_XPERMN = 6'b001000;
  localparam logic [5:0] OP_XPERMB = 6'b010000;
  localparam logic [5:0] OP_XPERMH = 6'b100000;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;

  logic        valid32;
  logic [5:0]  ops32;
  logic [31:0] rs1_32, rs2_32;
  logic        busy32, ready32;
  logic [31:0] result32;

  logic        valid64;
  logic [5:0]  ops64;
  logic [63:0] rs1_64, rs2_64;
  logic        busy64, ready64;
  logic [63:0] result64;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  frv_bitmanip_mc #(.XLEN(32), .CLMUL_STEP(4)) dut32 (
    .g_clk     (clock),
    .g_reset   (reset),
    .flush     (flush),
    .valid     (valid32),
    .op_clmul  (ops32[0]),
    .op_clmulh (ops32[1]),
    .op_clmulr (ops32[2]),
    .op_xpermn (ops32[3]),
    .op_xpermb (ops32[4]),
    .op_xpermh (ops32[5]),
    .rs1       (rs1_32),
    .rs2       (rs2_32),
    .busy      (busy32),
    .ready     (ready32),
    .result    (result32)
  );

  frv_bitmanip_mc #(.XLEN(64), .CLMUL_STEP(8)) dut64 (
    .g_clk     (clock),
    .g_reset   (reset),
    .flush     (flush),
    .valid     (valid64),
    .op_clmul  (ops64[0]),
    .op_clmulh (ops64[1]),
    .op_clmulr (ops64[2]),
    .op_xpermn (ops64[3]),
    .op_xpermb (ops64[4]),
    .op_xpermh (ops64[5]),
    .rs1       (rs1_64),
    .rs2       (rs2_64),
    .busy      (busy64),
    .ready     (ready64),
    .result    (result64)
  );

  // Advance to the next cycle, landing 1 unit after the rising edge.
  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  // Single comparison point: counts it and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Issue one op in the current cycle (cycle 0), hold it until ready or a
  // 40-cycle budget runs out, and report result, ready cycle and busy count.
  // lat stays -1 if ready never came.
  task automatic applyStimulus(input bit wide, input logic [5:0] op,
                               input logic [63:0] a, input logic [63:0] b,
                               output logic [63:0] res, output int lat,
                               output int busyCnt);
    res     = '0;
    lat     = -1;
    busyCnt = 0;
    if (wide) begin
      valid64 = 1'b1; ops64 = op; rs1_64 = a; rs2_64 = b;
    end else begin
      valid32 = 1'b1; ops32 = op; rs1_32 = a[31:0]; rs2_32 = b[31:0];
    end
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      nextCycle();
      if (wide ? busy64 : busy32) busyCnt++;
      if (wide ? ready64 : ready32) begin
        lat = c;
        res = wide ? result64 : {32'b0, result32};
      end
    end
    valid32 = 1'b0; ops32 = OP_NONE;
    valid64 = 1'b0; ops64 = OP_NONE;
  endtask

  // Hold inputs idle for n cycles and count any ready pulse on dut32.
  task automatic idleWatch(input int n, output int readyCnt);
    readyCnt = 0;
    for (int c = 0; c < n; c++) begin
      nextCycle();
      if (ready32) readyCnt++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [63:0] res;
    int          lat;
    int          bc;
    int          rc;

    reset = 1'b1; flush = 1'b0;
    valid32 = 1'b0; ops32 = OP_NONE; rs1_32 = '0; rs2_32 = '0;
    valid64 = 1'b0; ops64 = OP_NONE; rs1_64 = '0; rs2_64 = '0;
    repeat (3) nextCycle();
    checkOutput("reset ready", {63'b0, ready32}, 64'd0);
    checkOutput("reset busy", {63'b0, busy32}, 64'd0);
    checkOutput("reset result", {32'b0, result32}, 64'd0);
    checkOutput("reset result64", result64, 64'd0);
    reset = 1'b0;
    nextCycle();

    // clmul 3 x 3 = 5, ready in cycle 9, busy in cycles 1-8.
    applyStimulus(1'b0, OP_CLMUL, 64'h3, 64'h3, res, lat, bc);
    checkOutput("clmul3x3 result", res, 64'h5);
    checkOutput("clmul3x3 latency", 64'(lat), 64'd9);
    checkOutput("clmul3x3 busy cycles", 64'(bc), 64'd8);
    nextCycle();
    applyStimulus(1'b0, OP_CLMULH, 64'h3, 64'h3, res, lat, bc);
    checkOutput("clmulh3x3 result", res, 64'h0);
    nextCycle();

    // Top-bit operands: product is x^62.
    applyStimulus(1'b0, OP_CLMULH, 64'h80000000, 64'h80000000, res, lat, bc);
    checkOutput("clmulh msb", res, 64'h40000000);
    nextCycle();
    applyStimulus(1'b0, OP_CLMULR, 64'h80000000, 64'h80000000, res, lat, bc);
    checkOutput("clmulr msb", res, 64'h80000000);
    checkOutput("clmulr latency", 64'(lat), 64'd9);
    nextCycle();
    applyStimulus(1'b0, OP_CLMUL, 64'h80000000, 64'h80000000, res, lat, bc);
    checkOutput("clmul msb", res, 64'h0);
    nextCycle();

    // Crossbar permutes: one-cycle latency, out-of-range indices give zero.
    applyStimulus(1'b0, OP_XPERMN, 64'h76543210, 64'hFEDC0123, res, lat, bc);
    checkOutput("xpermn result", res, 64'h00000123);
    checkOutput("xpermn latency", 64'(lat), 64'd1);
    checkOutput("xpermn busy cycles", 64'(bc), 64'd0);
    nextCycle();
    applyStimulus(1'b0, OP_XPERMB, 64'hAABBCCDD, 64'h00010204, res, lat, bc);
    checkOutput("xpermb result", res, 64'hDDCCBB00);
    nextCycle();

    // No op bits set: ready in cycle 1 with zero result.
    applyStimulus(1'b0, OP_NONE, 64'h12345678, 64'h9ABCDEF0, res, lat, bc);
    checkOutput("noop result", res, 64'h0);
    checkOutput("noop latency", 64'(lat), 64'd1);
    nextCycle();

    // flush together with valid in IDLE: request must be ignored.
    valid32 = 1'b1; ops32 = OP_CLMUL; rs1_32 = 32'h3; rs2_32 = 32'h3; flush = 1'b1;
    nextCycle();
    valid32 = 1'b0; ops32 = OP_NONE; flush = 1'b0;
    #1;
    checkOutput("idle flush busy", {63'b0, busy32}, 64'd0);
    idleWatch(12, rc);
    checkOutput("idle flush no ready", 64'(rc), 64'd0);

    // clmul flushed in cycle 4: no ready, IDLE in cycle 5.
    valid32 = 1'b1; ops32 = OP_CLMUL; rs1_32 = 32'h3; rs2_32 = 32'h3;
    repeat (3) nextCycle();
    checkOutput("flush pre busy", {63'b0, busy32}, 64'd1);
    nextCycle();
    flush = 1'b1;
    #1;
    checkOutput("flush cycle ready", {63'b0, ready32}, 64'd0);
    nextCycle();
    flush = 1'b0; valid32 = 1'b0; ops32 = OP_NONE;
    #1;
    checkOutput("flush after busy", {63'b0, busy32}, 64'd0);
    idleWatch(12, rc);
    checkOutput("flush no ready", 64'(rc), 64'd0);
    applyStimulus(1'b0, OP_XPERMH, 64'h12345678, 64'h00000001, res, lat, bc);
    checkOutput("xpermh result", res, 64'h56781234);
    nextCycle();

    // Reset asserted in cycle 3 of a clmul.
    valid32 = 1'b1; ops32 = OP_CLMUL; rs1_32 = 32'h3; rs2_32 = 32'h3;
    repeat (3) nextCycle();
    reset = 1'b1;
    nextCycle();
    checkOutput("midreset ready", {63'b0, ready32}, 64'd0);
    checkOutput("midreset busy", {63'b0, busy32}, 64'd0);
    checkOutput("midreset result", {32'b0, result32}, 64'd0);
    reset = 1'b0; valid32 = 1'b0; ops32 = OP_NONE;
    idleWatch(12, rc);
    checkOutput("midreset no ready", 64'(rc), 64'd0);

    // 64-bit instance, 8 bits per step.
    applyStimulus(1'b1, OP_CLMUL, 64'hFFFFFFFFFFFFFFFF, 64'h3, res, lat, bc);
    checkOutput("clmul64 result", res, 64'h0000000000000001);
    checkOutput("clmul64 latency", 64'(lat), 64'd9);
    nextCycle();
    applyStimulus(1'b1, OP_CLMULH, 64'hFFFFFFFFFFFFFFFF, 64'h3, res, lat, bc);
    checkOutput("clmulh64 result", res, 64'h0000000000000001);
    nextCycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
